// File: rtl/jpeg_mcu_assembler.sv
// Ping-pong MCU buffer between the IDCT row output and the downstream pixel sink.
// Each bank holds one MCU (one 8x8 block per component) and is drained under valid/ready.
module jpeg_mcu_assembler #(
  parameter int PIXEL_W    = 8,
  parameter int N_COMP     = 3,
  parameter int INTERLEAVE = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [8*PIXEL_W-1:0]          row_in,
  input  logic                          valid_in,
  input  logic                          final_in,
  output logic [8*N_COMP*PIXEL_W-1:0]   row_out,
  output logic [1:0]                    comp_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          last_out,
  output logic                          final_out,
  output logic                          overflow_out,
  output logic                          err_out
);

  localparam int ROW_W = 8 * PIXEL_W;
  localparam int DEPTH = 8 * N_COMP;
  localparam int NBEAT = (INTERLEAVE != 0) ? 8 : DEPTH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(NBEAT - 1);

  logic [ROW_W-1:0] mem [2][DEPTH];
  logic [1:0]       full_q;
  logic [1:0]       fin_q;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  logic             wr_ok;
  logic             wr_done;
  logic             xfer;
  logic             rd_done;
  logic             load;
  logic             ld_bank;
  logic [IDX_W-1:0] ld_idx;
  logic [8*N_COMP*PIXEL_W-1:0] beat_row;
  logic [1:0]       beat_comp;
  logic             beat_last;
  logic             beat_fin;

  assign wr_ok   = valid_in & ~full_q[wr_bank];
  assign wr_done = wr_ok & (wr_idx == WR_LAST);
  assign xfer    = valid_out & ready_in;
  assign rd_done = xfer & (rd_idx == RD_LAST);

  // Choose which beat goes into the output register at this edge; a finished
  // MCU hands over straight to the other bank when it is already full.
  always_comb begin
    load    = 1'b0;
    ld_bank = rd_bank;
    ld_idx  = rd_idx;
    if (!valid_out) begin
      load = full_q[rd_bank];
    end else if (xfer) begin
      if (rd_done) begin
        ld_bank = ~rd_bank;
        ld_idx  = '0;
        load    = full_q[~rd_bank];
      end else begin
        ld_idx = rd_idx + 1'b1;
        load   = 1'b1;
      end
    end
  end

  always_comb begin
    beat_row  = '0;
    beat_comp = '0;
    if (INTERLEAVE != 0) begin
      for (int c = 0; c < N_COMP; c++) begin
        beat_row[c*ROW_W +: ROW_W] = mem[ld_bank][IDX_W'(c * 8) + ld_idx];
      end
    end else begin
      beat_row[ROW_W-1:0] = mem[ld_bank][ld_idx];
      beat_comp           = 2'(ld_idx >> 3);
    end
    beat_last = (ld_idx == RD_LAST);
    beat_fin  = beat_last & fin_q[ld_bank];
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      mem[wr_bank][wr_idx] <= row_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      full_q       <= '0;
      fin_q        <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_idx       <= '0;
      rd_idx       <= '0;
      row_out      <= '0;
      comp_out     <= '0;
      valid_out    <= 1'b0;
      last_out     <= 1'b0;
      final_out    <= 1'b0;
      overflow_out <= 1'b0;
      err_out      <= 1'b0;
    end else begin
      if (wr_ok) begin
        if (wr_done) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (valid_in && full_q[wr_bank]) overflow_out <= 1'b1;
      if (valid_in && final_in && (wr_idx != WR_LAST)) err_out <= 1'b1;
      // The bank completing a write is never the one completing a drain.
      if (wr_done) begin
        full_q[wr_bank] <= 1'b1;
        fin_q[wr_bank]  <= final_in;
      end
      if (rd_done) begin
        full_q[rd_bank] <= 1'b0;
        fin_q[rd_bank]  <= 1'b0;
      end
      if (!valid_out || xfer) begin
        valid_out <= load;
        rd_bank   <= ld_bank;
        rd_idx    <= ld_idx;
        row_out   <= load ? beat_row : '0;
        comp_out  <= load ? beat_comp : 2'b00;
        last_out  <= load & beat_last;
        final_out <= load & beat_fin;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_mcu_assembler.sv
// Bench for jpeg_mcu_assembler: an interleaved and a planar instance share one input stream;
// a row-level model queues expected beats and a negedge monitor checks every transfer.
module tb_jpeg_mcu_assembler;

  typedef struct packed {
    logic [191:0] row;
    logic [1:0]   comp;
    logic         last;
    logic         fin;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [63:0]  row_in;
  logic         valid_in;
  logic         final_in;
  logic         ready_in = 1'b0;
  logic [191:0] row_o [2];
  logic [1:0]   comp_o [2];
  logic         valid_o [2];
  logic         last_o [2];
  logic         final_o [2];
  logic         ovf_o [2];
  logic         err_o [2];

  int    total = 0;
  int    bad = 0;
  int    mode = 0;
  beat_t expq [2][$];
  logic [63:0] cur [2][24];
  int    wpos [2];
  logic  exp_ovf [2];
  logic  exp_err [2];
  beat_t prev [2];
  bit    stall [2];

  always #5 clk = ~clk;

  jpeg_mcu_assembler #(.PIXEL_W(8), .N_COMP(3), .INTERLEAVE(1)) dut_il (
    .clk_in(clk), .rst_in(rst_n), .row_in(row_in), .valid_in(valid_in), .final_in(final_in),
    .row_out(row_o[0]), .comp_out(comp_o[0]), .valid_out(valid_o[0]), .ready_in(ready_in),
    .last_out(last_o[0]), .final_out(final_o[0]), .overflow_out(ovf_o[0]), .err_out(err_o[0]));

  jpeg_mcu_assembler #(.PIXEL_W(8), .N_COMP(3), .INTERLEAVE(0)) dut_pl (
    .clk_in(clk), .rst_in(rst_n), .row_in(row_in), .valid_in(valid_in), .final_in(final_in),
    .row_out(row_o[1]), .comp_out(comp_o[1]), .valid_out(valid_o[1]), .ready_in(ready_in),
    .last_out(last_o[1]), .final_out(final_o[1]), .overflow_out(ovf_o[1]), .err_out(err_o[1]));

  // Downstream readiness patterns: 0 always, 1 alternate, 2 random, 3 stalled.
  always @(posedge clk) begin
    #1;
    case (mode)
      0: ready_in = 1'b1;
      1: ready_in = ~ready_in;
      2: ready_in = 1'($urandom_range(0, 1));
      default: ready_in = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        beat_t cb;
        beat_t e;
        cb = {row_o[d], comp_o[d], last_o[d], final_o[d]};
        if (stall[d]) begin
          total++;
          if (!valid_o[d] || cb !== prev[d]) begin
            bad++;
            $display("FAIL hold d%0d: valid=%0b beat=%h required valid=1 beat=%h", d, valid_o[d], cb, prev[d]);
          end
        end
        if (valid_o[d] && ready_in) begin
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL beat d%0d: got unexpected beat %h, required none", d, cb);
          end else begin
            e = expq[d].pop_front();
            if (cb !== e) begin
              bad++;
              $display("FAIL beat d%0d: got %h required %h", d, cb, e);
            end
          end
        end
        stall[d] = valid_o[d] && !ready_in;
        prev[d]  = cb;
      end
    end
  end

  function automatic int nb(input int d);
    return (d == 0) ? 8 : 24;
  endfunction

  function automatic int held(input int d);
    return (expq[d].size() + nb(d) - 1) / nb(d);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_mcu(input int d, input logic fin);
    beat_t b;
    if (d == 0) begin
      for (int r = 0; r < 8; r++) begin
        b.row  = {cur[0][16+r], cur[0][8+r], cur[0][r]};
        b.comp = 2'd0;
        b.last = (r == 7);
        b.fin  = fin && (r == 7);
        expq[0].push_back(b);
      end
    end else begin
      for (int i = 0; i < 24; i++) begin
        b.row  = {128'b0, cur[1][i]};
        b.comp = 2'(i / 8);
        b.last = (i == 23);
        b.fin  = fin && (i == 23);
        expq[1].push_back(b);
      end
    end
  endtask

  task automatic send_row(input logic [63:0] data, input logic fin);
    bit drop [2];
    for (int d = 0; d < 2; d++) drop[d] = (held(d) >= 2);
    row_in   = data;
    valid_in = 1'b1;
    final_in = fin;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    final_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (fin && wpos[d] != 23) exp_err[d] = 1'b1;
      if (drop[d]) begin
        exp_ovf[d] = 1'b1;
      end else begin
        cur[d][wpos[d]] = data;
        if (wpos[d] == 23) begin
          push_mcu(d, fin);
          wpos[d] = 0;
        end else begin
          wpos[d]++;
        end
      end
    end
  endtask

  task automatic gate();
    int t = 0;
    while (!(expq[0].size() <= 8 && expq[1].size() <= 24)) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 3000) begin
        total++;
        bad++;
        $display("FAIL gate: got %0d/%0d pending beats after %0d cycles, required <=8/<=24", expq[0].size(), expq[1].size(), t);
        break;
      end
    end
  endtask

  // kind 0: pixel = row index; 1: random rows back-to-back; 2: random rows with gaps.
  task automatic send_mcu(input int kind, input int fin_row);
    logic [63:0] data;
    gate();
    for (int i = 0; i < 24; i++) begin
      data = (kind == 0) ? {8{8'(i)}} : {$urandom, $urandom};
      send_row(data, i == fin_row);
      if (kind == 2) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (expq[0].size() != 0 || expq[1].size() != 0) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 4000) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d/%0d beats outstanding, required 0/0", expq[0].size(), expq[1].size());
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      wpos[d]    = 0;
      exp_ovf[d] = 1'b0;
      exp_err[d] = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  task automatic check_idle();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("idle row d%0d", d), row_o[d], 256'd0);
      chk($sformatf("idle comp d%0d", d), comp_o[d], 256'd0);
      chk($sformatf("idle valid d%0d", d), valid_o[d], 256'd0);
      chk($sformatf("idle last d%0d", d), last_o[d], 256'd0);
      chk($sformatf("idle final d%0d", d), final_o[d], 256'd0);
      chk($sformatf("idle ovf d%0d", d), ovf_o[d], 256'd0);
      chk($sformatf("idle err d%0d", d), err_o[d], 256'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n    = 1'b0;
    row_in   = '0;
    valid_in = 1'b0;
    final_in = 1'b0;
    mode     = 0;
    do_reset();
    @(negedge clk);
    check_idle();

    // Index pattern, continuous ready, first-beat latency.
    @(posedge clk);
    #1;
    send_mcu(0, -1);
    @(negedge clk);
    chk("latency k+0 d0", valid_o[0], 256'd0);
    @(negedge clk);
    chk("latency k+1 d0", valid_o[0], 256'd1);
    chk("latency k+1 d1", valid_o[1], 256'd1);
    wait_drain();

    // Alternating ready with a 20-cycle stall.
    mode = 1;
    send_mcu(1, -1);
    send_mcu(1, -1);
    mode = 3;
    repeat (20) @(posedge clk);
    #1;
    mode = 1;
    send_mcu(1, -1);
    wait_drain();

    // Random readiness and random input gaps.
    mode = 2;
    repeat (4) send_mcu(2, -1);
    wait_drain();

    // Overflow: three MCUs against a stalled sink.
    mode = 3;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 72; i++) begin
      send_row({$urandom, $urandom}, 1'b0);
      if (i == 47 || i == 48) begin
        for (int d = 0; d < 2; d++) chk($sformatf("ovf row%0d d%0d", i, d), ovf_o[d], exp_ovf[d]);
      end
    end
    mode = 0;
    wait_drain();
    for (int d = 0; d < 2; d++) chk($sformatf("ovf sticky d%0d", d), ovf_o[d], exp_ovf[d]);

    // Final on the last row of the second MCU, then final on a mid-MCU row.
    mode = 1;
    send_mcu(1, -1);
    send_mcu(1, 23);
    wait_drain();
    for (int d = 0; d < 2; d++) chk($sformatf("err clean d%0d", d), err_o[d], exp_err[d]);
    send_mcu(1, 5);
    wait_drain();
    for (int d = 0; d < 2; d++) chk($sformatf("err set d%0d", d), err_o[d], exp_err[d]);

    // Reset in the middle of a drain, then a fresh MCU.
    mode = 3;
    send_mcu(1, -1);
    mode = 1;
    t = 0;
    while (expq[0].size() > 5 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mid-drain reached", expq[0].size() <= 5, 256'd1);
    do_reset();
    @(negedge clk);
    check_idle();
    mode = 0;
    @(posedge clk);
    #1;
    send_mcu(0, -1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_mcu_assembler.md
# jpeg_mcu_assembler

Parametrised output stage for the multi-component JPEG decoder. It collects the 8-pixel rows produced by the 2-D IDCT, one 8×8 block per component, into ping-pong MCU banks. It then drains each completed MCU downstream under a valid/ready handshake, either component-interleaved per row or planar. It replaces the direct IDCT-row output of the single-component decoder, which has no buffering and no backpressure.

## Interface
- PIXEL_W, 8, bits per pixel sample
- N_COMP, 3, components (blocks) per MCU, 1..4
- INTERLEAVE, 1, 1 = one output row carries row r of every component; 0 = planar, one component row per beat
- clk_in  input  1  clock; all logic on rising edge
- rst_in  input  1  reset, synchronous, active-low
- row_in  input  8*PIXEL_W  IDCT output row, pixel 0 in LSBs
- valid_in  input  1  row_in valid; single-cycle strobe, no backpressure
- final_in  input  1  qualifies valid_in: last row of the last MCU of the image
- row_out  output  8*N_COMP*PIXEL_W  output row; component c occupies bits [(c+1)*8*PIXEL_W-1 : c*8*PIXEL_W]; planar mode uses component-0 slot only, upper bits 0
- comp_out  output  2  component index of row_out (planar); 0 in interleave mode
- valid_out  output  1  row_out valid
- ready_in  input  1  downstream accepts row_out
- last_out  output  1  final beat of current MCU
- final_out  output  1  final beat of the image's last MCU
- overflow_out  output  1  sticky: a row was dropped
- err_out  output  1  sticky: final_in seen on a non-MCU-boundary row

## Operation
- Storage: 2 banks × (8*N_COMP) rows × 8*PIXEL_W bits; per-bank full flag and final flag.
- Write side: wr_bank and wr_idx (0..8*N_COMP-1). An input row arrives in order comp 0 rows 0..7, comp 1 rows 0..7, and so on. Each accepted row is written to index wr_idx = c*8+r.
- At wr_idx = 8*N_COMP-1: set full[wr_bank], latch final_in into final[wr_bank], toggle wr_bank, set wr_idx = 0.
- valid_in while full[wr_bank] = 1: row dropped, wr_idx unchanged, overflow_out set.
- final_in on any other index: ignored apart from setting err_out.
- Read side: rd_bank and rd_idx.
- Interleave: 8 beats per MCU. Beat r = {comp N_COMP-1 row r, …, comp 0 row r}.
- Planar: 8*N_COMP beats in write order. comp_out = rd_idx/8.
- last_out = 1 on the final beat of an MCU. final_out = last_out & final[rd_bank].
- Handshake: a beat transfers on valid_out & ready_in. row_out, comp_out, last_out and final_out stay stable while valid_out & !ready_in. valid_out never drops without a transfer.
- Last-beat transfer: clears full[rd_bank] and final[rd_bank], toggles rd_bank, sets rd_idx = 0.
- After final_out transfers, the block is ready for the next image; no reset is needed.
- Reset: all outputs 0, both banks empty, all indices/banks 0, sticky flags cleared. Reset mid-MCU discards all buffered data.

## Timing
- Output is registered. If the last row of an MCU is sampled at edge k, first-beat valid_out is high after edge k+1 (when the read side is idle).
- Throughput: 1 beat/cycle while ready_in = 1.
- If the other bank is already full when the last beat transfers at edge m, its beat 0 is loaded at edge m, with no bubble. Otherwise valid_out falls after edge m.
- A bank freed at edge m is writable from edge m+1. valid_in at edge m targeting that bank counts as overflow.
- Simultaneous write-completion of one bank and drain-completion of the other in the same cycle are both honoured.
- Latency with continuous ready_in: 2 cycles from last input row of an MCU to its first output beat.

## Test plan
- N_COMP=3, INTERLEAVE=1: feed 24 rows with row value = index (0..23 in each pixel), ready_in = 1. Expect 8 beats: beat r carries r, 8+r and 16+r in slots 0/1/2; last_out on beat 7; first valid 2 cycles after row 23.
- Planar mode: same stimulus. Expect 24 beats in input order, comp_out 0,0,…,1,…,2; last_out on beat 23.
- Backpressure: ready_in toggles 1010…, plus a 20-cycle stall mid-MCU. Expect row_out stable during stalls and no beat lost or duplicated.
- Overflow: ready_in = 0, feed 3 MCUs (72 rows). Expect the first 48 rows buffered, overflow_out = 1 from row 49, and two intact MCUs drained when ready_in rises.
- Final: 2 MCUs with final_in on row 47. Expect final_out only on the 16th beat. final_in on row 5 sets err_out and produces no final_out.
- Reset: assert rst_in low mid-drain of MCU 0. Expect all outputs 0 the next cycle; a fresh MCU afterwards drains correctly from beat 0.
